// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: 32-step shift-add multiply and restoring divide,
// finishing with a single register-file write-back beat.
module muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data
);
    // state  | meaning
    // S_IDLE | waiting for start; operands latched on the accepting edge
    // S_RUN  | one multiply/divide iteration per edge, DATA_W edges total
    // S_DONE | single write-back cycle, wb_en high
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [1:0]            op_q,      op_d;
    logic [DATA_W-1:0]     opnd_q,    opnd_d;
    logic [REG_ADDR_W-1:0] dest_q,    dest_d;
    logic [2*DATA_W-1:0]   acc_q,     acc_d;
    logic [REG_ADDR_W-1:0] wb_reg_q,  wb_reg_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;

    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_rem;
    logic [DATA_W:0]       div_diff;
    logic                  div_ge;
    logic [2*DATA_W-1:0]   div_next;
    logic [2*DATA_W-1:0]   iter_next;

    // acc holds {hi, lo}: MUL keeps the multiplier in lo and shifts right,
    // DIVU keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        div_rem  = acc_q[2*DATA_W-1:DATA_W-1];
        div_diff = div_rem - {1'b0, opnd_q};
        div_ge   = ~div_diff[DATA_W];
        div_next = {(div_ge ? div_diff[DATA_W-1:0] : div_rem[DATA_W-1:0]),
                    acc_q[DATA_W-2:0], div_ge};

        iter_next = op_q[1] ? div_next : mul_next;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        dest_d    = dest_q;
        acc_d     = acc_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    dest_d = dest_reg;
                    cnt_d  = '0;
                    opnd_d = op[1] ? b : a;
                    acc_d  = {{DATA_W{1'b0}}, (op[1] ? a : b)};
                    if (op[1] && (b == '0)) begin
                        state_d   = S_DONE;
                        wb_reg_d  = dest_reg;
                        wb_data_d = op[0] ? a : {DATA_W{1'b1}};
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = iter_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d   = S_DONE;
                    wb_reg_d  = dest_q;
                    // odd ops (MUL hi, DIVU rem) take the upper half
                    wb_data_d = op_q[0] ? iter_next[2*DATA_W-1:DATA_W]
                                        : iter_next[DATA_W-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            dest_q    <= '0;
            acc_q     <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            dest_q    <= dest_d;
            acc_q     <= acc_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign wb_en   = (state_q == S_DONE);
    assign wb_reg  = wb_reg_q;
    assign wb_data = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs,
// a negedge monitor pops and compares register, data and arrival cycle.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  dest_reg = '0;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    muldiv_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .dest_reg(dest_reg), .busy(busy), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got reg=%0d data=%0h expected no write-back (cycle %0d)",
                         wb_reg, wb_data, cyc);
            end else begin
                e = sb.pop_front();
                check("wb_reg", 64'(wb_reg), 64'(e.rg));
                check("wb_data", 64'(wb_data), 64'(e.data));
                check("wb_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] d, input logic [31:0] ex, input bit div0);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_issue", 64'(busy), 64'd0);
        start = 1'b1; op = o; a = av; b = bv; dest_reg = d;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        e.rg = d; e.data = ex; e.due = cyc + (div0 ? 0 : 32);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", 64'((sb.size() != 0) || busy), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_reg", 64'(wb_reg), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 7*6 with busy length measured
        issue(2'b00, 32'd7, 32'd6, 5'd9, 32'd42, 1'b0);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'd33);
        repeat (2) @(negedge clk);
        check("hold_wb_data", 64'(wb_data), 64'd42);
        check("hold_wb_reg", 64'(wb_reg), 64'd9);
        check("hold_wb_en", 64'(wb_en), 64'd0);

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0); wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0); wait_done();
        issue(2'b00, 32'h1234_5678, 32'h0000_0010, 5'd3, 32'h2345_6780, 1'b0); wait_done();
        issue(2'b01, 32'h1234_5678, 32'h0000_0010, 5'd4, 32'h0000_0001, 1'b0); wait_done();
        issue(2'b10, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0); wait_done();
        issue(2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 1'b0); wait_done();
        issue(2'b10, 32'hFFFF_FFFF, 32'h10, 5'd7, 32'h0FFF_FFFF, 1'b0); wait_done();
        issue(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd8, 32'h0000_000F, 1'b0); wait_done();
        issue(2'b10, 32'd5, 32'd10, 5'd0, 32'd0, 1'b0); wait_done();
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'd0, 1'b0); wait_done();
        issue(2'b10, 32'd55, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b1); wait_done();
        issue(2'b11, 32'd55, 32'd0, 5'd11, 32'd55, 1'b1); wait_done();

        // start while busy is ignored; start held through DONE taken once idle
        issue(2'b00, 32'd3, 32'd5, 5'd12, 32'd15, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; dest_reg = 5'd13;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_ignored", 64'(busy), 64'd1);
        n = 0;
        @(negedge clk);
        while (!wb_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_wb_seen", 64'(wb_en), 64'd1);
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; dest_reg = 5'd14;
        @(posedge clk); #1;
        check("idle_after_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_accepted_idle", 64'(busy), 64'd1);
        e.rg = 5'd14; e.data = 32'd6; e.due = cyc + 32;
        sb.push_back(e);
        wait_done();

        // reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3; dest_reg = 5'd15;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy), 64'd1 - 64'd1);
        check("midrst_wb_en", 64'(wb_en), 64'd0);
        check("midrst_wb_data", 64'(wb_data), 64'd0);
        check("midrst_wb_reg", 64'(wb_reg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_stays_idle", 64'(busy), 64'd0);
        check("midrst_data_zero", 64'(wb_data), 64'd0);

        // reset and start on the same edge
        issue(2'b00, 32'd7, 32'd6, 5'd9, 32'd42, 1'b0); wait_done();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; dest_reg = 5'd16;
        @(posedge clk); #1;
        check("rststart_busy", 64'(busy), 64'd0);
        check("rststart_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);
        check("rststart_idle", 64'(busy), 64'd0);

        issue(2'b11, 32'd100, 32'd7, 5'd17, 32'd2, 1'b0); wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
